// File: rtl/sort_pkg.sv
// Shared types and constants for the serial odd-even transposition sorter.
package sort_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_N     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SORT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Even passes hold floor(n/2) pairs, odd passes floor((n-1)/2); n passes alternate starting even.
  function automatic int sort_cycles(input int n);
    return ((n + 1) / 2) * (n / 2) + (n / 2) * ((n - 1) / 2);
  endfunction

endpackage

// File: rtl/cmp_swap.sv
// Single compare-swap cell: s0 gets the smaller word, s1 the larger; equal words pass straight through.
module cmp_swap
  import sort_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] s0,
  output logic [WIDTH-1:0] s1
);

  logic doSwap;

  always_comb begin
    doSwap = (x0 > x1);
    s0     = doSwap ? x1 : x0;
    s1     = doSwap ? x0 : x1;
  end

endmodule

// File: rtl/sort_sequencer.sv
// Serial block sorter: load N words, run a fixed odd-even transposition schedule through one
// shared compare-swap cell, then stream the block out smallest first.
module sort_sequencer
  import sort_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = DEFAULT_N
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done
);

  localparam int T  = sort_cycles(N);
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N);
  localparam int SW = $clog2(T + 1);

  state_t           state;
  logic [WIDTH-1:0] dataBuf [N];
  logic [CW-1:0]    wrIdx;
  logic [CW-1:0]    rdIdx;
  logic [CW-1:0]    pairIdx;
  logic [CW-1:0]    passIdx;
  logic [SW-1:0]    sortCnt;

  logic [IW-1:0]    idxA;
  logic [IW-1:0]    idxB;
  logic [IW-1:0]    nextRd;
  logic [WIDTH-1:0] lowWord;
  logic [WIDTH-1:0] highWord;
  logic             lastSort;
  logic             lastPair;

  always_comb begin
    idxA     = pairIdx[IW-1:0];
    idxB     = idxA + IW'(1);
    nextRd   = rdIdx[IW-1:0] + IW'(1);
    lastSort = (int'(sortCnt) == T - 1);
    lastPair = (int'(pairIdx) + 3 >= N);
  end

  cmp_swap #(.WIDTH(WIDTH)) uCmpSwap (
    .x0(dataBuf[idxA]),
    .x1(dataBuf[idxB]),
    .s0(lowWord),
    .s1(highWord)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      for (int i = 0; i < N; i++) dataBuf[i] <= '0;
      wrIdx     <= '0;
      rdIdx     <= '0;
      pairIdx   <= '0;
      passIdx   <= '0;
      sortCnt   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= LOAD;
          in_ready <= 1'b1;
          wrIdx    <= '0;
        end

        LOAD: begin
          if (in_valid) begin
            dataBuf[wrIdx[IW-1:0]] <= in_data;
            if (wrIdx == CW'(N - 1)) begin
              state    <= SORT;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              done     <= (T == 1);
              wrIdx    <= '0;
              pairIdx  <= '0;
              passIdx  <= '0;
              sortCnt  <= '0;
            end else begin
              wrIdx <= wrIdx + CW'(1);
            end
          end
        end

        SORT: begin
          dataBuf[idxA] <= lowWord;
          dataBuf[idxB] <= highWord;
          sortCnt       <= sortCnt + SW'(1);
          done          <= (int'(sortCnt) == T - 2);
          // The next pass starts at pair 1 after an even pass and pair 0 after an odd one.
          if (!lastPair) begin
            pairIdx <= pairIdx + CW'(2);
          end else begin
            passIdx <= passIdx + CW'(1);
            pairIdx <= passIdx[0] ? CW'(0) : CW'(1);
          end
          if (lastSort) begin
            state     <= DRAIN;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= (idxA == '0) ? lowWord : dataBuf[0];
            rdIdx     <= '0;
            sortCnt   <= '0;
            pairIdx   <= '0;
            passIdx   <= '0;
          end
        end

        DRAIN: begin
          if (out_ready) begin
            if (rdIdx == CW'(N - 1)) begin
              state     <= LOAD;
              out_valid <= 1'b0;
              out_data  <= '0;
              in_ready  <= 1'b1;
              rdIdx     <= '0;
              wrIdx     <= '0;
            end else begin
              rdIdx    <= rdIdx + CW'(1);
              out_data <= dataBuf[nextRd];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_sequencer.sv
// Directed bench for sort_sequencer (WIDTH=4, N=8): hand-computed sorted blocks, sort timing and handshakes.
module tb_sort_sequencer;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  logic [3:0] vec  [8];
  logic [3:0] expv [8];

  sort_sequencer #(.WIDTH(4), .N(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Feed vec into the block; a word is taken on an edge only when in_ready was high before it.
  task automatic applyStimulus(input bit gapMode, input bit holdAfter);
    int  idx   = 0;
    int  guard = 0;
    bit  accepted;
    while (idx < 8 && guard < 200) begin
      in_valid = !(gapMode && ($urandom_range(0, 2) == 0));
      in_data  = vec[idx];
      accepted = in_valid && in_ready;
      @(posedge clock); #1;
      guard++;
      if (accepted) idx++;
    end
    if (holdAfter) begin
      in_valid = 1'b1;
      in_data  = 4'd5;
    end else begin
      in_valid = 1'b0;
    end
    checkOutput("loadCount", idx, 8);
  endtask

  task automatic checkSortPhase();
    int cycles     = 0;
    int doneCount  = 0;
    int doneAt     = 0;
    int readySeen  = 0;
    checkOutput("busyStart", busy, 1);
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      if (done) begin
        doneCount++;
        doneAt = cycles;
      end
      if (in_ready) readySeen++;
      @(posedge clock); #1;
    end
    checkOutput("sortCycles", cycles, 28);
    checkOutput("donePulses", doneCount, 1);
    checkOutput("doneCycle", doneAt, 28);
    checkOutput("sortInReady", readySeen, 0);
    checkOutput("firstOutValid", out_valid, 1);
    checkOutput("doneAfter", done, 0);
  endtask

  task automatic collectOutput(input bit stallMode);
    int         got       = 0;
    int         guard     = 0;
    int         phase     = 0;
    int         readySeen = 0;
    bit         prevStall = 0;
    logic [3:0] prevData  = '0;
    logic [3:0] words [8];
    while (got < 8 && guard < 200) begin
      out_ready = stallMode ? (phase == 0 || phase == 3) : 1'b1;
      phase     = (phase + 1) % 4;
      if (prevStall) begin
        checkOutput("stallValid", out_valid, 1);
        checkOutput("stallData", out_data, prevData);
      end
      if (in_ready) readySeen++;
      if (out_valid && out_ready) begin
        words[got] = out_data;
        got++;
        prevStall = 0;
      end else begin
        prevStall = out_valid;
        prevData  = out_data;
      end
      @(posedge clock); #1;
      guard++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("drainCount", got, 8);
    checkOutput("validDrop", out_valid, 0);
    checkOutput("drainInReady", readySeen, 0);
    checkOutput("reloadReady", in_ready, 1);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("word%0d", i), words[i], expv[i]);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    clock     = 1'b0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2 reset = 1'b0;
    #2;
    checkOutput("rstInReady", in_ready, 0);
    checkOutput("rstOutValid", out_valid, 0);
    checkOutput("rstOutData", out_data, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    #8 reset = 1'b1;
    #1;
    checkOutput("idleReady", in_ready, 0);
    @(posedge clock); #1;
    checkOutput("loadReady", in_ready, 1);

    vec  = '{4'd7, 4'd3, 4'd5, 4'd1, 4'd6, 4'd2, 4'd4, 4'd0};
    expv = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    applyStimulus(1'b0, 1'b0);
    checkSortPhase();
    collectOutput(1'b0);

    vec  = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8};
    expv = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    applyStimulus(1'b0, 1'b0);
    checkSortPhase();
    collectOutput(1'b0);

    vec  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    expv = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    applyStimulus(1'b0, 1'b0);
    checkSortPhase();
    collectOutput(1'b0);

    // Duplicates, with in_valid=1/in_data=5 held through SORT and DRAIN.
    vec  = '{4'd9, 4'd9, 4'd2, 4'd9, 4'd2, 4'd2, 4'd9, 4'd2};
    expv = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd9, 4'd9, 4'd9, 4'd9};
    applyStimulus(1'b0, 1'b1);
    checkSortPhase();
    collectOutput(1'b0);

    vec  = '{4'd10, 4'd4, 4'd12, 4'd1, 4'd8, 4'd3, 4'd15, 4'd6};
    expv = '{4'd1, 4'd3, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd15};
    applyStimulus(1'b1, 1'b0);
    checkSortPhase();
    collectOutput(1'b1);

    // Reset on SORT cycle 10, then a fresh block after the single IDLE cycle.
    vec = '{4'd7, 4'd3, 4'd5, 4'd1, 4'd6, 4'd2, 4'd4, 4'd0};
    applyStimulus(1'b0, 1'b0);
    repeat (9) begin
      @(posedge clock); #1;
    end
    checkOutput("busyMidSort", busy, 1);
    reset = 1'b0;
    #1;
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstInReady", in_ready, 0);
    checkOutput("midRstOutValid", out_valid, 0);
    checkOutput("midRstOutData", out_data, 0);
    checkOutput("midRstDone", done, 0);
    #1 reset = 1'b1;
    #1;
    checkOutput("midIdleReady", in_ready, 0);
    @(posedge clock); #1;
    checkOutput("midLoadReady", in_ready, 1);
    vec  = '{4'd3, 4'd1, 4'd2, 4'd0, 4'd7, 4'd5, 4'd6, 4'd4};
    expv = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    applyStimulus(1'b0, 1'b0);
    checkSortPhase();
    collectOutput(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sort_sequencer.md
Name: sort_sequencer

Overview:
- Sorts a block of N unsigned words using one shared compare-swap unit, time-multiplexed across element pairs by an odd-even transposition schedule.
- Loads words serially through a valid/ready input, sorts in a fixed number of cycles, then streams the words out in ascending order through a valid/ready output.
- Sits between a word producer and a consumer as the serial, area-lean alternative to a fully parallel sorting network.

Parameters:
- WIDTH, 4, bits per element (unsigned).
- N, 8, elements per block; N >= 2.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  in_data holds a valid word.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  WIDTH  input word.
- out_valid  out  1  out_data holds a valid sorted word.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  WIDTH  sorted output word, smallest first.
- busy  out  1  high while in SORT state.
- done  out  1  one-cycle pulse on the last SORT cycle.

Behaviour:
- Reset (reset=0, async): state=IDLE; buffer buf[0..N-1], all counters and phase cleared to 0. in_ready=0, out_valid=0, out_data=0, busy=0, done=0. Asserting reset mid-operation discards the block in flight.
- States: IDLE -> LOAD unconditionally on the first clock after reset release. LOAD -> SORT after the N-th accepted word. SORT -> DRAIN after the final compare-swap. DRAIN -> LOAD after the N-th output handshake.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: buf[wr_idx] <= in_data, wr_idx++.
  - In-state gaps in in_valid are allowed.
- SORT:
  - in_ready=0, busy=1.
  - Each cycle performs exactly one compare-swap on (buf[i], buf[i+1]), with results written back the same edge.
  - Even pass: i = 0,2,4,... while i+1 < N. Odd pass: i = 1,3,5,... while i+1 < N.
  - Passes alternate even, odd, starting even; N passes total.
  - Sort cycles T = ceil(N/2)*floor(N/2) + floor(N/2)*floor((N-1)/2). For N=8, T = 16 + 12 = 28.
  - Duration is fixed, independent of data; there is no early exit.
  - done=1 during cycle T only.
- Compare-swap: swap only when buf[i] > buf[i+1] (unsigned compare). Equal values are not swapped, so the sort is stable.
- DRAIN:
  - out_valid=1 and out_data=buf[rd_idx], rd_idx starting at 0.
  - On out_valid&out_ready: rd_idx++.
  - While out_valid&!out_ready, out_data stays stable.
  - out_valid drops the cycle after the N-th handshake.
  - in_ready=0 throughout; in_valid is ignored.
- Latency: the first output word is valid on the cycle after the last SORT cycle. Minimum block period is N + T + N cycles plus one IDLE cycle after reset.
- Counters: wr_idx/rd_idx width = $clog2(N+1). Pair index and pass counter are sized to N. All counters reset to 0 on each state entry.
- Simultaneous events: no input and output overlap exists by construction; the next LOAD starts the cycle after the last DRAIN handshake.

Decomposition:
- Shared package sort_pkg:
  - state enum {IDLE, LOAD, SORT, DRAIN}, 2 bits.
  - constant function sort_cycles(N) returning T.
  - default WIDTH/N constants.
- One sub-module, cmp_swap (param WIDTH):
  - inputs x0, x1; outputs s0 = min, s1 = max.
  - swaps only when x0 > x1.
  - purely combinational, instantiated once.
- Controller, counters and buffer mux/demux stay in sort_sequencer.

Test Plan (WIDTH=4, N=8):
- Load 7,3,5,1,6,2,4,0 back-to-back -> busy high exactly 28 cycles, done pulses once on cycle 28, outputs 0,1,2,3,4,5,6,7.
- Load 15,14,13,12,11,10,9,8 (worst case) -> outputs 8..15, still 28 sort cycles; then load 0..7 already sorted -> outputs 0..7 unchanged, 28 cycles.
- Load 9,9,2,9,2,2,9,2 (duplicates) -> outputs 2,2,2,2,9,9,9,9.
- Random in_valid gaps, out_ready toggling 1-0-0-1 -> exactly 8 words out, no loss or duplication, out_data stable while stalled.
- in_valid held high during SORT/DRAIN with value 5 -> in_ready=0, value never enters the buffer, output matches the loaded block only.
- reset=0 pulsed on SORT cycle 10 -> outputs immediately at reset values; after release, one IDLE cycle, then a fresh load of 3,1,2,0,7,5,6,4 yields 0..7.
